// File: rtl/tenthirty_pkg.sv
// Shared definitions for the ten-and-a-half card engine: FSM state encoding
// and rank-to-half-point conversion.
package tenthirty_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DEAL_P  = 3'd1,
    S_DEAL_D  = 3'd2,
    S_HIT_P   = 3'd3,
    S_HIT_D   = 3'd4,
    S_COMPARE = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam int HP_W = 5;

  function automatic logic rank_ok(input logic [3:0] rank);
    return (rank >= 4'd1) && (rank <= 4'd13);
  endfunction

  // Number cards count their face value (doubled into half-points); J/Q/K count one half.
  function automatic logic [HP_W-1:0] rank_hp(input logic [3:0] rank);
    if (rank <= 4'd10) return {rank, 1'b0};
    else               return 5'd1;
  endfunction

endpackage

// File: rtl/tenthirty_hand.sv
// One hand of cards: running half-point total and card count with clear/add.
// Adds beyond MAX_CARDS are dropped so neither field can wrap.
module tenthirty_hand
  import tenthirty_pkg::*;
#(
  parameter int MAX_CARDS = 5,
  parameter int TW        = $clog2(MAX_CARDS*20+1),
  parameter int CW        = $clog2(MAX_CARDS+1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            add,
  input  logic [HP_W-1:0] card_hp,
  output logic [TW-1:0]   total,
  output logic [CW-1:0]   cnt
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_CARDS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total <= '0;
      cnt   <= '0;
    end else if (clr) begin
      total <= '0;
      cnt   <= '0;
    end else if (add && (cnt < MAX_C)) begin
      total <= total + TW'(card_hp);
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tenthirty_engine.sv
// Ten-and-a-half game engine: deals, hits, stands and scores player vs dealer.
// Optional macro TENTHIRTY_AUTO_DEALER_EN makes the dealer draw automatically below DEALER_STAND_H.
module tenthirty_engine
  import tenthirty_pkg::*;
#(
  parameter int MAX_CARDS      = 5,
  parameter int ROUNDS         = 4,
  parameter int LIMIT_H        = 21,
  parameter int DEALER_STAND_H = 14,
  localparam int TW            = $clog2(MAX_CARDS*20+1),
  localparam int CW            = $clog2(MAX_CARDS+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          btn_hit,
  input  logic          btn_stand,
  output logic          card_req,
  input  logic          card_valid,
  input  logic [3:0]    card_val,
  output logic [2:0]    state,
  output logic [TW-1:0] p_total,
  output logic [TW-1:0] d_total,
  output logic [CW-1:0] p_cnt,
  output logic [CW-1:0] d_cnt,
  output logic          win_p,
  output logic          win_d,
  output logic [3:0]    round_cnt,
  output logic          game_done
);

  if ((MAX_CARDS < 2) || (MAX_CARDS > 8)) begin : g_bad_max_cards
    $error("MAX_CARDS must be in 2..8");
  end
  if ((ROUNDS < 1) || (ROUNDS > 15)) begin : g_bad_rounds
    $error("ROUNDS must be in 1..15");
  end
  if ((DEALER_STAND_H < 1) || (DEALER_STAND_H > LIMIT_H)) begin : g_bad_stand
    $error("DEALER_STAND_H must be in 1..LIMIT_H");
  end

  localparam logic [TW-1:0] LIMIT_T  = TW'(LIMIT_H);
  localparam logic [CW-1:0] MAX_C    = CW'(MAX_CARDS);
  localparam logic [3:0]    ROUNDS_R = 4'(ROUNDS);
`ifdef TENTHIRTY_AUTO_DEALER_EN
  localparam logic [TW-1:0] STAND_T  = TW'(DEALER_STAND_H);
`endif

  state_t          st, st_nxt;
  logic            req_nxt, win_p_nxt, win_d_nxt, done_nxt;
  logic [3:0]      rnd_nxt;
  logic            clr_hands, add_p, add_d, go_cmp;
  logic            hit, stand, accept, p_wins;
  logic [HP_W-1:0] hp;

  // Buttons count only when pressed alone and no card is outstanding.
  assign hit    = btn_hit & ~btn_stand & ~card_req;
  assign stand  = btn_stand & ~btn_hit & ~card_req;
  assign accept = card_req & card_valid & rank_ok(card_val);
  assign hp     = rank_hp(card_val);
  assign p_wins = (p_total <= LIMIT_T) && ((d_total > LIMIT_T) || (p_total > d_total));
  assign state  = st;

  tenthirty_hand #(.MAX_CARDS(MAX_CARDS), .TW(TW), .CW(CW)) u_player (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr_hands),
    .add     (add_p),
    .card_hp (hp),
    .total   (p_total),
    .cnt     (p_cnt)
  );

  tenthirty_hand #(.MAX_CARDS(MAX_CARDS), .TW(TW), .CW(CW)) u_dealer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr_hands),
    .add     (add_d),
    .card_hp (hp),
    .total   (d_total),
    .cnt     (d_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      card_req  <= 1'b0;
      win_p     <= 1'b0;
      win_d     <= 1'b0;
      round_cnt <= 4'd0;
      game_done <= 1'b0;
    end else begin
      st        <= st_nxt;
      card_req  <= req_nxt;
      win_p     <= win_p_nxt;
      win_d     <= win_d_nxt;
      round_cnt <= rnd_nxt;
      game_done <= done_nxt;
    end
  end

  always_comb begin
    st_nxt    = st;
    req_nxt   = card_req;
    win_p_nxt = win_p;
    win_d_nxt = win_d;
    rnd_nxt   = round_cnt;
    done_nxt  = game_done;
    clr_hands = 1'b0;
    add_p     = 1'b0;
    add_d     = 1'b0;
    go_cmp    = 1'b0;

    unique case (st)
      S_IDLE: begin
        if (hit) begin
          clr_hands = 1'b1;
          win_p_nxt = 1'b0;
          win_d_nxt = 1'b0;
          if (round_cnt != 4'hF) rnd_nxt = round_cnt + 4'd1;
          st_nxt    = S_DEAL_P;
        end
      end
      S_DEAL_P: begin
        if (!card_req) begin
          req_nxt = 1'b1;
        end else if (accept) begin
          add_p   = 1'b1;
          req_nxt = 1'b0;
          st_nxt  = S_DEAL_D;
        end
      end
      S_DEAL_D: begin
        if (!card_req) begin
          req_nxt = 1'b1;
        end else if (accept) begin
          add_d   = 1'b1;
          req_nxt = 1'b0;
          st_nxt  = S_HIT_P;
        end
      end
      S_HIT_P: begin
        // Automatic exits are judged on settled totals, one cycle after the last card.
        if (card_req) begin
          if (accept) begin
            add_p   = 1'b1;
            req_nxt = 1'b0;
          end
        end else if (p_total > LIMIT_T) begin
          go_cmp = 1'b1;
        end else if ((p_total == LIMIT_T) || (p_cnt == MAX_C)) begin
          st_nxt = S_HIT_D;
        end else if (hit) begin
          req_nxt = 1'b1;
        end else if (stand) begin
          st_nxt = S_HIT_D;
        end
      end
      S_HIT_D: begin
        if (card_req) begin
          if (accept) begin
            add_d   = 1'b1;
            req_nxt = 1'b0;
          end
        end else if ((d_total >= LIMIT_T) || (d_cnt == MAX_C)) begin
          go_cmp = 1'b1;
`ifdef TENTHIRTY_AUTO_DEALER_EN
        end else if (d_total < STAND_T) begin
          req_nxt = 1'b1;
        end else begin
          go_cmp = 1'b1;
        end
`else
        end else if (hit) begin
          req_nxt = 1'b1;
        end else if (stand) begin
          go_cmp = 1'b1;
        end
`endif
      end
      S_COMPARE: begin
        if (stand) begin
          if (round_cnt < ROUNDS_R) begin
            st_nxt = S_IDLE;
          end else begin
            st_nxt   = S_DONE;
            done_nxt = 1'b1;
          end
        end
      end
      S_DONE: begin
        done_nxt = 1'b1;
      end
      default: begin
        st_nxt  = S_IDLE;
        req_nxt = 1'b0;
      end
    endcase

    // Result is latched on the way into COMPARE; ties fall to the dealer.
    if (go_cmp) begin
      st_nxt    = S_COMPARE;
      win_p_nxt = p_wins;
      win_d_nxt = ~p_wins;
    end
  end

endmodule
